// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the shared-adder arbiter and its round-robin chooser.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int STATS_CNT_W = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin chooser: first requester above last_grant, wrapping.
module rr_pick
  import adder_share_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  logic [IDX_W-1:0] cand;

  // Offset N revisits last_grant itself, so a lone requester always wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % N);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one latency-ADD_LAT adder among NUM_REQ clients.
// Optional per-requester grant counters: define ADDER_SHARE_ARBITER_STATS_EN.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [W:0]           rsp_sum,
  output logic [W-1:0]         add_in1,
  output logic [W-1:0]         add_in2,
  input  logic [W:0]           add_out,
  output logic                 busy
`ifdef ADDER_SHARE_ARBITER_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_grant, gnt_idx, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic             pick_any;
  logic [W-1:0]     op_a, op_b;
  logic [W:0]       sum_q;
  logic [2:0]       lat_cnt;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any_req    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant is only offered in IDLE, response only in RESP, so the two never overlap.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (lat_cnt == 3'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gnt_idx] = 1'b1;
        if (rsp_ready[gnt_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      gnt_idx    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      sum_q      <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_a       <= req_a[int'(pick_idx)*W +: W];
            op_b       <= req_b[int'(pick_idx)*W +: W];
            gnt_idx    <= pick_idx;
            last_grant <= pick_idx;
          end
        end
        ISSUE: lat_cnt <= 3'(ADD_LAT - 1);
        WAIT: begin
          if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
          else                 sum_q   <= add_out;
        end
        default: ;
      endcase
    end
  end

  assign add_in1 = op_a;
  assign add_in2 = op_b;
  assign rsp_sum = sum_q;
  assign busy    = (state != IDLE);

`ifdef ADDER_SHARE_ARBITER_STATS_EN
  logic [STATS_CNT_W-1:0] cnt [NUM_REQ];

  // Counters saturate so a long run cannot wrap a busy requester back to a small count.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && cnt[i] != {STATS_CNT_W{1'b1}}) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: per-cycle model compare plus literal checks.
module tb_adder_share_arbiter;

  localparam int N       = 4;
  localparam int W       = 4;
  localparam int ADD_LAT = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W:0]     rsp_sum, add_out;
  logic [W-1:0]   add_in1, add_in2;
  logic           busy;
`ifdef ADDER_SHARE_ARBITER_STATS_EN
  logic           stats_clr;
  logic [N*8-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(N), .W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_out   (add_out),
    .busy      (busy)
`ifdef ADDER_SHARE_ARBITER_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  // Registered adder with ADD_LAT stages of latency
  logic [W:0] pipe [ADD_LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_in1} + {1'b0, add_in2};
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_out = pipe[ADD_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model: an operation is an (owner, a, b, age) record; age counts cycles since grant.
  bit         m_op;
  int         m_g, m_age, m_ptr;
  logic [W-1:0] m_a, m_b;

  always @(negedge clk) begin
    logic [N-1:0] e_rr, e_rv;
    logic [W:0]   e_sum;
    int           p;
    if (!rst_n) begin
      m_op  = 1'b0;
      m_ptr = N - 1;
    end else begin
      e_rr = '0;
      e_rv = '0;
      p    = -1;
      if (!m_op) begin
        p = pick(req_valid, m_ptr);
        if (p >= 0) e_rr[p] = 1'b1;
      end else if (m_age >= ADD_LAT + 2) begin
        e_rv[m_g] = 1'b1;
      end
      checkOutput("m_req_ready", req_ready, e_rr);
      checkOutput("m_rsp_valid", rsp_valid, e_rv);
      checkOutput("m_busy", busy, m_op);
      if (m_op) begin
        checkOutput("m_add_in1", add_in1, m_a);
        checkOutput("m_add_in2", add_in2, m_b);
        if (m_age >= ADD_LAT + 2) begin
          e_sum = {1'b0, m_a} + {1'b0, m_b};
          checkOutput("m_rsp_sum", rsp_sum, e_sum);
        end
      end
      if (!m_op && p >= 0) begin
        m_op  = 1'b1;
        m_g   = p;
        m_ptr = p;
        m_a   = req_a[p*W +: W];
        m_b   = req_b[p*W +: W];
        m_age = 1;
      end else if (m_op) begin
        if (m_age >= ADD_LAT + 2) begin
          if (rsp_ready[m_g]) m_op = 1'b0;
        end else begin
          m_age++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] rr);
    @(posedge clk); #1;
    req_valid = v;
    rsp_ready = rr;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic waitIdle();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy && c < 30);
    if (busy) timeoutFail("wait_idle");
  endtask

  // Single operation for requester r, with a short stall using other requesters' rsp_ready.
  task automatic runOp(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [W:0] sum);
    logic [N-1:0] one;
    one = N'(1) << r;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    applyStimulus(one, '0);
    @(negedge clk);
    checkOutput("op_grant", req_ready, one);
    applyStimulus('0, '0);
    @(negedge clk);
    checkOutput("op_add_in1", add_in1, a);
    checkOutput("op_add_in2", add_in2, b);
    lat = 1;
    while (!rsp_valid[r] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[r]) timeoutFail("op_rsp");
    sum = rsp_sum;
    applyStimulus('0, ~one);
    @(negedge clk);
    checkOutput("op_rsp_hold", rsp_valid, one);
    checkOutput("op_sum_hold", rsp_sum, sum);
    applyStimulus('0, one);
    applyStimulus('0, '0);
  endtask

  initial begin
    int           lat, ng, ns;
    logic [W:0]   sum;
    int           order [5];
    logic [W:0]   sums [5];

    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
`ifdef ADDER_SHARE_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_add_in1", add_in1, 0);
    checkOutput("rst_rsp_sum", rsp_sum, 0);

    $display("[TB] single request 5+3");
    runOp(0, 4'd5, 4'd3, lat, sum);
    checkOutput("t1_latency", lat, 3);
    checkOutput("t1_sum", sum, 8);

    $display("[TB] overflow 15+15");
    runOp(0, 4'd15, 4'd15, lat, sum);
    checkOutput("t2_sum", sum, 30);
    checkOutput("t2_carry", sum[W], 1);

    $display("[TB] fairness, all requesters");
    doReset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i);
      req_b[i*W +: W] = W'(1);
    end
    req_valid = '1;
    rsp_ready = '1;
    ng = 0;
    ns = 0;
    for (int c = 0; c < 60 && ns < 5; c++) begin
      @(negedge clk);
      if (req_ready != 0 && ng < 5) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) order[ng] = i;
        ng++;
      end
      if (rsp_valid != 0 && ns < 5) begin
        sums[ns] = rsp_sum;
        ns++;
      end
    end
    if (ns < 5) timeoutFail("fair_rsp");
    applyStimulus('0, '1);
    checkOutput("fair_g0", order[0], 0);
    checkOutput("fair_g1", order[1], 1);
    checkOutput("fair_g2", order[2], 2);
    checkOutput("fair_g3", order[3], 3);
    checkOutput("fair_g4", order[4], 0);
    checkOutput("fair_s0", sums[0], 1);
    checkOutput("fair_s1", sums[1], 2);
    checkOutput("fair_s2", sums[2], 3);
    checkOutput("fair_s3", sums[3], 4);
    checkOutput("fair_s4", sums[4], 1);
    waitIdle();

    $display("[TB] backpressure on requester 2");
    req_a[2*W +: W] = 4'd6;
    req_b[2*W +: W] = 4'd7;
    req_a[0 +: W] = 4'd1;
    req_b[0 +: W] = 4'd1;
    applyStimulus(4'b0100, '0);
    @(negedge clk);
    checkOutput("bp_grant", req_ready, 4'b0100);
    applyStimulus(4'b0001, '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[2] && lat < 20);
    if (!rsp_valid[2]) timeoutFail("bp_rsp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", rsp_valid, 4'b0100);
      checkOutput("bp_rsp_sum", rsp_sum, 13);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_no_grant", req_ready, 0);
    end
    applyStimulus(4'b0001, 4'b0100);
    @(negedge clk);
    checkOutput("bp_release_cycle", rsp_valid, 4'b0100);
    applyStimulus(4'b0001, '0);
    @(negedge clk);
    checkOutput("bp_idle", busy, 0);
    checkOutput("bp_next_grant", req_ready, 4'b0001);
    applyStimulus('0, '1);
    waitIdle();

    $display("[TB] reset during WAIT");
    req_a[1*W +: W] = 4'd2;
    req_b[1*W +: W] = 4'd2;
    req_a[3*W +: W] = 4'd9;
    req_b[3*W +: W] = 4'd4;
    applyStimulus(4'b0010, '1);
    @(negedge clk);
    checkOutput("rs_grant1", req_ready, 4'b0010);
    applyStimulus('0, '1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("rs_no_rsp", rsp_valid, 0);
    end
    applyStimulus(4'b1010, '1);
    @(negedge clk);
    checkOutput("rs_ptr_reset", req_ready, 4'b0010);
    applyStimulus('0, '1);
    waitIdle();

`ifdef ADDER_SHARE_ARBITER_STATS_EN
    $display("[TB] grant counters");
    checkOutput("st_cnt1", grant_cnt[15:8], 1);
    checkOutput("st_cnt3", grant_cnt[31:24], 0);
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    checkOutput("st_clr", grant_cnt[15:8], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered adder datapath among NUM_REQ requesters. The adder has W-bit operands, a (W+1)-bit sum, and ADD_LAT cycles of latency.
- Round-robin arbitration, one operation in flight at a time.
- Valid/ready handshake on the request side and on the response side.
- Sits between client blocks and the adder wrapper; drives the adder's operand inputs and captures its output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 4, operand width; sum width is W+1.
- ADD_LAT, 1, cycles from operand applied to valid sum at add_out (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active low.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  one-hot accept pulse (grant).
- req_a  input  NUM_REQ*W  packed operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*W  packed operand B.
- rsp_valid  output  NUM_REQ  one-hot; result available for requester i.
- rsp_ready  input  NUM_REQ  requester i takes the result.
- rsp_sum  output  W+1  shared result bus; valid only while rsp_valid is nonzero.
- add_in1  output  W  operand A to the adder.
- add_in2  output  W  operand B to the adder.
- add_out  input  W+1  sum from the adder.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0.
  - FSM goes to IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Latency counter = 0.
- Reset is synchronous: it is sampled only on the rising clk edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - In the same cycle, pulse req_ready[g] for exactly 1 cycle (combinational from req_valid and state).
  - Register the operands req_a[g] and req_b[g], register g, set last_grant = g, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - Drive add_in1/add_in2 with the registered operands; they stay stable until the state returns to IDLE.
  - Load counter = ADD_LAT-1, go to WAIT.
- WAIT:
  - While counter != 0, decrement.
  - At counter == 0, capture add_out into the sum register and go to RESP.
- Request-to-rsp_valid latency = ADD_LAT+2 cycles after the req_ready cycle (1 cycle to RESP, 1 for ISSUE, ADD_LAT in WAIT).
- RESP:
  - rsp_valid[g]=1 and rsp_sum=sum are held stable until rsp_ready[g]=1.
  - On that cycle go to IDLE. Arbitration for the next request happens in the following cycle, so there is no back-to-back grant in the RESP cycle.
  - rsp_ready bits of other requesters are ignored.
- Arithmetic: rsp_sum = add_out exactly as captured. The arbiter performs no arithmetic or width change; the carry is bit W.
- Requester dropping req_valid before its grant: simply not considered. No grant is issued while req_valid is 0.
- Simultaneous requests from all requesters: strict rotation 0,1,2,3,0,... with no starvation. Worst-case wait = NUM_REQ-1 full operations.
- Single requester asserting continuously: granted on every IDLE visit.
- Reset asserted mid-operation (any state):
  - The in-flight result is discarded and no rsp_valid is produced for it.
  - The pointer returns to NUM_REQ-1.
- rsp_valid and req_ready are never both nonzero in the same cycle.

Optional Feature:
- Macro: ADDER_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt, width NUM_REQ*8: a per-requester 8-bit saturating count of grants (stops at 255).
  - Adds input stats_clr (1 bit), which zeroes all counters synchronously.
  - Counters are cleared by rst_n.
- Undefined: the ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package adder_share_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP), 2 bits.
  - Function for the width of the requester index: clog2(NUM_REQ).
  - Constant STATS_CNT_W = 8.
- One sub-module is natural: rr_pick.
  - Combinational round-robin chooser.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant, index, and any_req.
  - Reusable by other shared-resource controllers.

Test Plan:
- Single request, W=4, ADD_LAT=1: requester 0 sends a=4'b0101, b=4'b0011 → req_ready[0] pulses 1 cycle, add_in1=5 and add_in2=3 from the ISSUE cycle, rsp_valid[0] 3 cycles after grant, rsp_sum=5'b01000 (8), held until rsp_ready[0].
- Overflow: a=15, b=15 → rsp_sum=30 (5'b11110), carry bit 4 set.
- Fairness: all 4 requesters hold req_valid with a=i, b=1 and take results immediately → grant order 0,1,2,3,0; sums 1,2,3,4,1.
- Backpressure: hold rsp_ready[2]=0 for 5 cycles → rsp_valid[2] and rsp_sum stay stable, busy=1, no new req_ready; release → IDLE the next cycle, next grant the cycle after.
- Reset mid-operation: assert rst_n=0 in WAIT, then release; keep all req_valid low for 10 cycles → no rsp_valid ever; then drive req_valid[1] and req_valid[3] → requester 1 is granted first (pointer reset).
- ADD_LAT=3 build: with a=7, b=2 → rsp_valid exactly 5 cycles after grant, sum=9. With STATS_EN, after 3 grants to requester 1 grant_cnt[15:8]=3; stats_clr → 0.
